multicycle_ctrl: RTL and testbench

//  Control unit FSM for the multicycle CPU. Sequences fetch/decode/execute/writeback and drives
//  all datapath enables and selects: PC register enable, PC mux4 select, IR load, register-file

---
 rtl/multicycle_ctrl.sv | 163 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle CPU: sequences fetch/decode/execute/writeback
// and drives every datapath enable, mux select and the memory handshake.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       ir_en,
  output logic       rf_we,
  output logic [1:0] wd_sel,
  output logic       zf_load,
  output logic       addr_sel,
  output logic       mem_req,
  output logic       mem_we,
  output logic       halted,
  output logic       err
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EX_ALU,
    S_EX_LI,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_HALT,
    S_ERR
  } state_t;

  localparam logic [7:0] LIM = 8'(TIMEOUT - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       w_wait;
  logic       w_tmo;
  logic       w_br_take;

  assign w_wait = (r_state == S_FETCH) || (r_state == S_MEM_RD)
               || (r_state == S_MEM_WR);
  assign w_tmo  = (r_cnt == LIM) && !mem_ack;

  always_comb begin
    w_br_take = 1'b0;
    unique case (opcode)
      4'b0101: w_br_take = 1'b1;
      4'b0110: w_br_take = zero;
      4'b0111: w_br_take = ~zero;
      default: w_br_take = 1'b0;
    endcase
  end

  // Counter only runs while waiting; any other cycle or an ack clears it,
  // so it is always zero on entry to a wait state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= 8'd0;
    end else begin
      if (w_wait && !mem_ack)
        r_cnt <= r_cnt + 8'd1;
      else
        r_cnt <= 8'd0;
      unique case (r_state)
        S_FETCH: begin
          if (mem_ack)    r_state <= S_DECODE;
          else if (w_tmo) r_state <= S_ERR;
        end
        S_DECODE: begin
          unique case (opcode)
            4'b0000: r_state <= S_FETCH;
            4'b0001: r_state <= S_EX_ALU;
            4'b0010: r_state <= S_EX_LI;
            4'b0011: r_state <= S_MEM_RD;
            4'b0100: r_state <= S_MEM_WR;
            4'b0101,
            4'b0110,
            4'b0111: r_state <= S_BRANCH;
            4'b1111: r_state <= S_HALT;
            default: r_state <= S_ERR;
          endcase
        end
        S_EX_ALU,
        S_EX_LI,
        S_MEM_WB,
        S_BRANCH: r_state <= S_FETCH;
        S_MEM_RD: begin
          if (mem_ack)    r_state <= S_MEM_WB;
          else if (w_tmo) r_state <= S_ERR;
        end
        S_MEM_WR: begin
          if (mem_ack)    r_state <= S_FETCH;
          else if (w_tmo) r_state <= S_ERR;
        end
        S_HALT:  r_state <= S_HALT;
        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_ERR;
      endcase
    end
  end

  // Outputs decode from state; reset forces them all low so no strobe leaks.
  always_comb begin
    pc_en    = 1'b0;
    pc_src   = 2'b00;
    ir_en    = 1'b0;
    rf_we    = 1'b0;
    wd_sel   = 2'b00;
    zf_load  = 1'b0;
    addr_sel = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    halted   = 1'b0;
    err      = 1'b0;
    if (!reset) begin
      unique case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_en   = mem_ack;
          pc_en   = mem_ack;
        end
        S_EX_ALU: begin
          rf_we   = 1'b1;
          zf_load = 1'b1;
        end
        S_EX_LI: begin
          rf_we  = 1'b1;
          wd_sel = 2'b01;
        end
        S_MEM_RD: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
        end
        S_MEM_WB: begin
          rf_we  = 1'b1;
          wd_sel = 2'b10;
        end
        S_MEM_WR: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          addr_sel = 1'b1;
        end
        S_BRANCH: begin
          pc_src = 2'b01;
          pc_en  = w_br_take;
        end
        S_HALT: halted = 1'b1;
        S_ERR: begin
          halted = 1'b1;
          err    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks instruction sequences and checks
// the full output vector each cycle against hand-built expectations.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ack;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       ir_en;
  logic       rf_we;
  logic [1:0] wd_sel;
  logic       zf_load;
  logic       addr_sel;
  logic       mem_req;
  logic       mem_we;
  logic       halted;
  logic       err;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ack(mem_ack), .pc_en(pc_en), .pc_src(pc_src), .ir_en(ir_en),
    .rf_we(rf_we), .wd_sel(wd_sel), .zf_load(zf_load),
    .addr_sel(addr_sel), .mem_req(mem_req), .mem_we(mem_we),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  // Order: pc_en pc_src ir_en rf_we wd_sel zf_load addr_sel req we halted err
  logic [12:0] obs;
  assign obs = {pc_en, pc_src, ir_en, rf_we, wd_sel, zf_load,
                addr_sel, mem_req, mem_we, halted, err};

  localparam logic [12:0] O_ZERO   = 13'b0_00_0_0_00_0_0_0_0_0_0;
  localparam logic [12:0] O_FWAIT  = 13'b0_00_0_0_00_0_0_1_0_0_0;
  localparam logic [12:0] O_FACK   = 13'b1_00_1_0_00_0_0_1_0_0_0;
  localparam logic [12:0] O_ALU    = 13'b0_00_0_1_00_1_0_0_0_0_0;
  localparam logic [12:0] O_LI     = 13'b0_00_0_1_01_0_0_0_0_0_0;
  localparam logic [12:0] O_RD     = 13'b0_00_0_0_00_0_1_1_0_0_0;
  localparam logic [12:0] O_WB     = 13'b0_00_0_1_10_0_0_0_0_0_0;
  localparam logic [12:0] O_WR     = 13'b0_00_0_0_00_0_1_1_1_0_0;
  localparam logic [12:0] O_BR_T   = 13'b1_01_0_0_00_0_0_0_0_0_0;
  localparam logic [12:0] O_BR_N   = 13'b0_01_0_0_00_0_0_0_0_0_0;
  localparam logic [12:0] O_HALT   = 13'b0_00_0_0_00_0_0_0_0_1_0;
  localparam logic [12:0] O_ERR    = 13'b0_00_0_0_00_0_0_0_0_1_1;

  task automatic chk(input string tag, input logic [12:0] exp);
    #1;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    mem_ack = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Fetch one instruction with an immediate ack; leaves us in DECODE.
  task automatic fetch(input logic [3:0] op);
    opcode  = op;
    mem_ack = 1'b1;
    chk("fetch_ack", O_FACK);
    cyc();
    mem_ack = 1'b0;
    chk("decode", O_ZERO);
    cyc();
  endtask

  initial begin
    reset   = 1'b1;
    opcode  = 4'd0;
    zero    = 1'b0;
    mem_ack = 1'b0;
    #2;
    chk("in_reset", O_ZERO);
    cyc();
    reset = 1'b0;
    chk("post_reset_fetch", O_FWAIT);

    // ALU loop: rf_we/zf_load every third cycle
    for (int i = 0; i < 2; i++) begin
      fetch(4'b0001);
      chk("ex_alu", O_ALU);
      cyc();
    end

    fetch(4'b0010);
    chk("ex_li", O_LI);
    cyc();

    // LOAD with 3 wait cycles, ack on 4th
    fetch(4'b0011);
    for (int i = 0; i < 3; i++) chk("mem_rd_wait", O_RD);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("mem_rd_wait", O_RD);
    end
    cyc();
    mem_ack = 1'b1;
    chk("mem_rd_ack", O_RD);
    cyc();
    mem_ack = 1'b0;
    chk("mem_wb", O_WB);
    cyc();
    chk("after_wb_fetch", O_FWAIT);

    // STORE zero-wait
    fetch(4'b0100);
    mem_ack = 1'b1;
    chk("mem_wr_ack", O_WR);
    cyc();
    mem_ack = 1'b0;
    chk("after_wr_fetch", O_FWAIT);

    // JZ taken / not taken, JNZ, JMP
    zero = 1'b1;
    fetch(4'b0110);
    chk("jz_taken", O_BR_T);
    cyc();
    zero = 1'b0;
    fetch(4'b0110);
    chk("jz_not", O_BR_N);
    cyc();
    fetch(4'b0111);
    chk("jnz_taken", O_BR_T);
    cyc();
    zero = 1'b1;
    fetch(4'b0101);
    chk("jmp", O_BR_T);
    cyc();

    // NOP -> back to FETCH; ack arrives in the 15th wait cycle
    fetch(4'b0000);
    for (int i = 0; i < 14; i++) begin
      chk("fetch_wait", O_FWAIT);
      cyc();
    end
    mem_ack = 1'b1;
    chk("fetch_ack_c15", O_FACK);
    cyc();
    mem_ack = 1'b0;
    chk("decode_after_c15", O_ZERO);
    cyc();

    // No ack for 15 cycles -> ERR, then absorbing
    for (int i = 0; i < 15; i++) begin
      chk("fetch_tmo_wait", O_FWAIT);
      cyc();
    end
    chk("fetch_timeout_err", O_ERR);
    mem_ack = 1'b1;
    cyc();
    chk("err_sticky", O_ERR);
    mem_ack = 1'b0;

    do_reset();
    chk("reset_from_err", O_FWAIT);
    fetch(4'b1010);
    chk("illegal_err", O_ERR);

    do_reset();
    fetch(4'b1111);
    for (int i = 0; i < 100; i++) begin
      chk("halt_hold", O_HALT);
      mem_ack = i[0];
      cyc();
    end
    mem_ack = 1'b0;

    // Async reset in MEM_WR drops strobes immediately
    do_reset();
    fetch(4'b0100);
    chk("mem_wr_wait", O_WR);
    reset = 1'b1;
    chk("reset_mid_wr", O_ZERO);
    cyc();
    chk("reset_hold", O_ZERO);
    reset = 1'b0;
    chk("release_fetch", O_FWAIT);

    // MEM_RD timeout -> ERR
    fetch(4'b0011);
    for (int i = 0; i < 15; i++) begin
      chk("rd_tmo_wait", O_RD);
      cyc();
    end
    chk("rd_timeout_err", O_ERR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
